// File: rtl/cpu_bus_xbar.sv
// CPU data-bus crossbar: parametrised address decode with priority, bus-error
// return, registered read path and nak tracking. Timeout abort: CPU_BUS_TIMEOUT_EN.
module cpu_bus_xbar #(
    parameter int                    N_SLAVE  = 8,
    parameter logic [N_SLAVE*32-1:0] SLV_BASE = {N_SLAVE{32'h0}},
    parameter logic [N_SLAVE*32-1:0] SLV_MASK = {N_SLAVE{32'hFFFF_FFFF}},
    parameter int                    TIMEOUT  = 255,
    parameter logic [31:0]           ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    m_stb,
    input  logic [31:0]             m_addr,
    input  logic [3:0]              m_we,
    output logic [31:0]             m_rdata,
    output logic                    m_nak,
    output logic                    m_err,
    output logic [N_SLAVE-1:0]      s_en,
    input  logic [N_SLAVE*32-1:0]   s_rdata,
    input  logic [N_SLAVE-1:0]      s_nak,
    output logic [31:0]             err_addr,
    output logic                    err_valid,
    input  logic                    err_clr
);

    logic [N_SLAVE-1:0] hit;
    logic [N_SLAVE-1:0] sel;
    logic               found;
    logic               miss;
    logic               nak_raw;
    logic               abort_now;
    logic               in_abort;
    logic               accept;

    logic [N_SLAVE-1:0] rd_sel_reg;
    logic               rd_err_reg;
    logic [31:0]        rd_term [N_SLAVE];
    logic [31:0]        rd_or;
    logic [31:0]        err_addr_reg;
    logic               err_valid_reg;

    // Reads and writes are routed identically; the byte mask only matters to slaves.
    logic               unused_we;
    assign unused_we = ^m_we;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVE; gi++) begin : g_decode
            assign hit[gi] = ((m_addr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32]);
            assign rd_term[gi] = rd_sel_reg[gi] ? s_rdata[32*gi +: 32] : 32'h0;
        end
    endgenerate

    // Overlapping windows resolve to the lowest channel index.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (hit[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign miss    = m_stb & ~|hit;
    assign nak_raw = m_stb & |(sel & s_nak);
    assign m_nak   = nak_raw & ~abort_now;
    assign m_err   = miss | abort_now;
    assign accept  = m_stb & ~m_nak;
    assign s_en    = (m_stb && !abort_now && !in_abort) ? sel : '0;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_WAIT     = 2'd1;
    localparam logic [1:0]  ST_ABORT    = 2'd2;
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [1:0]  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;

    assign abort_now = (state_reg == ST_WAIT) && (cnt_reg == TIMEOUT_CNT) && nak_raw;
    assign in_abort  = (state_reg == ST_ABORT);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (nak_raw) begin
                    state_next = ST_WAIT;
                    cnt_next   = 16'd1;
                end
            end
            ST_WAIT: begin
                if (abort_now) begin
                    state_next = ST_ABORT;
                    cnt_next   = 16'd0;
                end else if (m_nak) begin
                    cnt_next = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
                end else begin
                    state_next = ST_IDLE;
                    cnt_next   = 16'd0;
                end
            end
            ST_ABORT: begin
                state_next = ST_IDLE;
                cnt_next   = 16'd0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 16'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end
`else
    // Without the abort path a nak stalls for as long as the slave asks.
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
    assign abort_now      = 1'b0;
    assign in_abort       = 1'b0;
`endif

    always_comb begin
        rd_or = 32'h0;
        for (int i = 0; i < N_SLAVE; i++) begin
            rd_or = rd_or | rd_term[i];
        end
    end

    assign m_rdata = rd_err_reg ? ERR_DATA : rd_or;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_sel_reg <= '0;
            rd_err_reg <= 1'b0;
        end else if (accept) begin
            rd_sel_reg <= m_err ? '0 : sel;
            rd_err_reg <= m_err;
        end else begin
            rd_sel_reg <= '0;
            rd_err_reg <= 1'b0;
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_addr_reg  <= 32'h0;
            err_valid_reg <= 1'b0;
        end else if (m_err) begin
            err_addr_reg  <= m_addr;
            err_valid_reg <= 1'b1;
        end else if (err_clr) begin
            err_valid_reg <= 1'b0;
        end
    end

    assign err_addr  = err_addr_reg;
    assign err_valid = err_valid_reg;

endmodule
